mem_axi_master_bridge: RTL

- Converts a single-port memory-style request interface (req/gnt/rvalid) into AXI4-Lite master transactions.
- It is the initiator-side counterpart of the AXI-Lite-slave-to-memory bridge. It lets a core or DMA with a memory port reach AXI-Lite peripherals on the SoC interconnect.
- One outstanding transaction at a time. Writes and reads are each completed fully before the next request is granted.

---
 rtl/mem_axi_pkg.sv | 21 ++
 rtl/mem_axi_master_bridge.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_axi_pkg.sv
// rtl/mem_axi_pkg.sv - shared types and constants for mem_axi_master_bridge
//
// Holds the bridge FSM state encoding and the AXI response codes, so the
// design and anything that inspects it agree on the values.
package mem_axi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    WR_RESP = 3'd2,
    READ    = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/mem_axi_master_bridge.sv
// rtl/mem_axi_master_bridge.sv - memory req/gnt/rvalid port to AXI4-Lite master bridge
//
// Purpose: lets a core or DMA with a simple memory port issue AXI4-Lite
// transactions. Exactly one transaction is in flight; the next request is
// granted only after the previous one has signalled rvalid_o.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   req_i / gnt_o                 memory request, combinational grant (IDLE only)
//   we_i, addr_i, wdata_i, be_i   request attributes, sampled on grant
//   rvalid_o, rdata_o, err_o      one-cycle completion pulse, read data, error
//   aw_* / w_* / b_*              AXI4-Lite write address, data, response
//   ar_* / r_*                    AXI4-Lite read address, data
module mem_axi_master_bridge
  import mem_axi_pkg::*;
#(
  parameter int                MEM_AW    = 16,
  parameter int                AXI_AW    = 32,
  parameter int                DW        = 32,
  parameter logic [AXI_AW-1:0] ADDR_BASE = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              req_i,
  output logic              gnt_o,
  input  logic              we_i,
  input  logic [MEM_AW-1:0] addr_i,
  input  logic [DW-1:0]     wdata_i,
  input  logic [DW/8-1:0]   be_i,
  output logic              rvalid_o,
  output logic [DW-1:0]     rdata_o,
  output logic              err_o,

  output logic [AXI_AW-1:0] aw_addr_o,
  output logic              aw_valid_o,
  input  logic              aw_ready_i,

  output logic [DW-1:0]     w_data_o,
  output logic [DW/8-1:0]   w_strb_o,
  output logic              w_valid_o,
  input  logic              w_ready_i,

  input  logic [1:0]        b_resp_i,
  input  logic              b_valid_i,
  output logic              b_ready_o,

  output logic [AXI_AW-1:0] ar_addr_o,
  output logic              ar_valid_o,
  input  logic              ar_ready_i,

  input  logic [DW-1:0]     r_data_i,
  input  logic [1:0]        r_resp_i,
  input  logic              r_valid_i,
  output logic              r_ready_o
);

  state_t              r_state;
  state_t              w_state_nxt;

  logic [AXI_AW-1:0]   r_axi_addr;
  logic [DW-1:0]       r_wdata;
  logic [DW/8-1:0]     r_be;
  logic [DW-1:0]       r_rdata;
  logic                r_err;
  logic                r_aw_done;
  logic                r_w_done;

  logic                w_grant;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_b_hs;
  logic                w_ar_hs;
  logic                w_r_hs;
  logic                w_wr_both;

  // Handshakes are decoded from registered state only, so no input-to-valid
  // combinational path exists on the AXI side.
  assign w_grant   = (r_state == IDLE) && req_i;
  assign w_aw_hs   = (r_state == WRITE) && !r_aw_done && aw_ready_i;
  assign w_w_hs    = (r_state == WRITE) && !r_w_done && w_ready_i;
  assign w_b_hs    = (r_state == WR_RESP) && b_valid_i;
  assign w_ar_hs   = (r_state == READ) && ar_ready_i;
  assign w_r_hs    = (r_state == RD_DATA) && r_valid_i;

  // AW and W may complete in either order or together; the write phase ends
  // once both have been seen, counting a handshake happening this cycle.
  assign w_wr_both = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (req_i) begin
          w_state_nxt = we_i ? WRITE : READ;
        end
      end
      WRITE: begin
        if (w_wr_both) begin
          w_state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        if (b_valid_i) begin
          w_state_nxt = DONE;
        end
      end
      READ: begin
        if (ar_ready_i) begin
          w_state_nxt = RD_DATA;
        end
      end
      RD_DATA: begin
        if (r_valid_i) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output decode. Valids are pure functions of state and the per-channel
  // done flags, so reset clears them asynchronously together with the state.
  always_comb begin
    gnt_o      = 1'b0;
    aw_valid_o = 1'b0;
    w_valid_o  = 1'b0;
    b_ready_o  = 1'b0;
    ar_valid_o = 1'b0;
    r_ready_o  = 1'b0;
    rvalid_o   = 1'b0;
    err_o      = 1'b0;
    case (r_state)
      IDLE: begin
        gnt_o = req_i;
      end
      WRITE: begin
        aw_valid_o = !r_aw_done;
        w_valid_o  = !r_w_done;
      end
      WR_RESP: begin
        b_ready_o = 1'b1;
      end
      READ: begin
        ar_valid_o = 1'b1;
      end
      RD_DATA: begin
        r_ready_o = 1'b1;
      end
      DONE: begin
        rvalid_o = 1'b1;
        err_o    = r_err;
      end
      default: begin
        gnt_o = 1'b0;
      end
    endcase
  end

  // Request capture and response capture. Request fields only change on a
  // grant, which keeps AXI address/data stable while valid is pending.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_axi_addr <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      if (w_grant) begin
        r_axi_addr <= AXI_AW'(addr_i) | ADDR_BASE;
        r_wdata    <= wdata_i;
        r_be       <= be_i;
        r_aw_done  <= 1'b0;
        r_w_done   <= 1'b0;
      end
      if (w_aw_hs) begin
        r_aw_done <= 1'b1;
      end
      if (w_w_hs) begin
        r_w_done <= 1'b1;
      end
      if (w_b_hs) begin
        r_err <= (b_resp_i != AXI_RESP_OKAY);
      end
      // rdata_o keeps the last read value across writes.
      if (w_r_hs) begin
        r_rdata <= r_data_i;
        r_err   <= (r_resp_i != AXI_RESP_OKAY);
      end
    end
  end

  assign aw_addr_o = r_axi_addr;
  assign ar_addr_o = r_axi_addr;
  assign w_data_o  = r_wdata;
  assign w_strb_o  = r_be;
  assign rdata_o   = r_rdata;

endmodule
